liteic_resp_router: RTL

- Read-response return path of the lite interconnect. Forward path: one master port fans out to NUM_REGIONS slave regions.
- On every accepted read request, the block records the destination region, taken from the address decoder's one-hot select and illegal flag, in an in-order tracking FIFO.
- Routes region responses back to the single master strictly in issue order.
- Synthesises a DECERR response for requests that decoded to an illegal address.

---
 rtl/liteic_pkg.sv | 41 ++++
 rtl/liteic_sync_fifo.sv | 60 ++++++
 rtl/liteic_resp_router.sv | 162 ++++++++++++++++
 3 files changed

// File: rtl/liteic_pkg.sv
// Shared types for the lite interconnect read-response return path.
// Latency: n/a (types and a combinational helper only).
// Backpressure: n/a.
// Contents: resp_t response codes, output-register state enum, tracking
// entry struct {illegal, rgn_idx}, onehot_to_idx lowest-set-bit encoder.
package liteic_pkg;

  typedef enum logic [1:0] {
    OKAY   = 2'b00,
    EXOKAY = 2'b01,
    SLVERR = 2'b10,
    DECERR = 2'b11
  } resp_t;

  typedef enum logic {
    OUT_EMPTY = 1'b0,
    OUT_HOLD  = 1'b1
  } out_state_t;

  // Region index width is fixed so the tracking entry can live in the package;
  // it covers any NUM_REGIONS up to MAX_REGIONS.
  localparam int RGN_IDX_W   = 8;
  localparam int MAX_REGIONS = 1 << RGN_IDX_W;

  typedef struct packed {
    logic                 illegal;
    logic [RGN_IDX_W-1:0] rgn_idx;
  } trk_entry_t;

  // Lowest set bit wins, so a malformed multi-hot select still maps to a
  // single, deterministic region.
  function automatic logic [RGN_IDX_W-1:0] onehot_to_idx(input logic [MAX_REGIONS-1:0] sel);
    logic [RGN_IDX_W-1:0] idx;
    idx = '0;
    for (int i = MAX_REGIONS - 1; i >= 0; i--) begin
      if (sel[i]) idx = RGN_IDX_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/liteic_sync_fifo.sv
// Generic synchronous FIFO holding the in-order request tracking entries.
// Latency: a pushed entry is visible at rdata from the cycle after the push.
// Backpressure: push ignored when full, pop ignored when empty.
// Ports: clk, rst (async, active-high), push/wdata, pop/rdata, full, empty, count.
module liteic_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       full,
  output logic                       empty,
  output logic [$clog2(DEPTH):0]     count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] cnt;
  logic             do_push;
  logic             do_pop;

  assign do_push = push && !full;
  assign do_pop  = pop && !empty;

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // Storage needs no reset: occupancy is governed entirely by cnt.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= wdata;
  end

  assign rdata = mem[rd_ptr];
  assign full  = (cnt == CNT_W'(DEPTH));
  assign empty = (cnt == '0);
  assign count = cnt;

endmodule

// File: rtl/liteic_resp_router.sv
// Read-response return path: routes region responses to the master in issue order, DECERR for illegal decodes.
// Latency: head-region response at cycle N appears on m_rvalid_o at N+1; illegal entry loads the cycle after it becomes head.
// Backpressure: held response stalls until m_rready_i; only the head region sees rgn_rready_o; issue_ready_o drops at MAX_OUTSTANDING.
// Ports: clk_i/rst_i (async, active-high); issue_* from the address decoder; rgn_* per-region response
// channels; m_* master response channel. Optional err_cnt_o when LITEIC_RESP_ERRCNT_EN is defined.
module liteic_resp_router
  import liteic_pkg::*;
#(
  parameter int NUM_REGIONS     = 16,
  parameter int DATA_WIDTH      = 32,
  parameter int MAX_OUTSTANDING = 4
) (
  input  logic                                  clk_i,
  input  logic                                  rst_i,
  input  logic                                  issue_valid_i,
  output logic                                  issue_ready_o,
  input  logic [NUM_REGIONS-1:0]                issue_rgn_select_i,
  input  logic                                  issue_illegal_i,
  input  logic [NUM_REGIONS-1:0]                rgn_rvalid_i,
  input  logic [NUM_REGIONS-1:0][DATA_WIDTH-1:0] rgn_rdata_i,
  input  logic [NUM_REGIONS-1:0][1:0]           rgn_rresp_i,
  output logic [NUM_REGIONS-1:0]                rgn_rready_o,
  output logic                                  m_rvalid_o,
  output logic [DATA_WIDTH-1:0]                 m_rdata_o,
  output logic [1:0]                            m_rresp_o,
  input  logic                                  m_rready_i
`ifdef LITEIC_RESP_ERRCNT_EN
  ,
  output logic [15:0]                           err_cnt_o
`endif
);

  localparam int CNT_W = $clog2(MAX_OUTSTANDING) + 1;

  // Tracking FIFO
  trk_entry_t       push_entry;
  trk_entry_t       head;
  logic             push;
  logic             pop;
  logic             trk_full;
  logic             trk_empty;
  logic [CNT_W-1:0] trk_count;

  always_comb begin
    push_entry.rgn_idx = onehot_to_idx(MAX_REGIONS'(issue_rgn_select_i));
    // An empty select is treated like a decode error.
    push_entry.illegal = issue_illegal_i || (issue_rgn_select_i == '0);
  end

  // Registered count only: a pop in the same cycle does not open a slot.
  assign issue_ready_o = (trk_count != CNT_W'(MAX_OUTSTANDING));
  assign push          = issue_valid_i && !trk_full;

  liteic_sync_fifo #(
    .WIDTH ($bits(trk_entry_t)),
    .DEPTH (MAX_OUTSTANDING)
  ) u_trk_fifo (
    .clk   (clk_i),
    .rst   (rst_i),
    .push  (push),
    .wdata (push_entry),
    .pop   (pop),
    .rdata (head),
    .full  (trk_full),
    .empty (trk_empty),
    .count (trk_count)
  );

  // Head region decode and response mux
  logic [NUM_REGIONS-1:0] head_dec;
  logic                   head_rvalid;
  logic [DATA_WIDTH-1:0]  head_rdata;
  logic [1:0]             head_rresp;

  always_comb begin
    head_dec    = '0;
    head_rvalid = 1'b0;
    head_rdata  = '0;
    head_rresp  = '0;
    for (int i = 0; i < NUM_REGIONS; i++) begin
      head_dec[i] = (head.rgn_idx == RGN_IDX_W'(i));
      if (head_dec[i]) begin
        head_rvalid = rgn_rvalid_i[i];
        head_rdata  = rgn_rdata_i[i];
        head_rresp  = rgn_rresp_i[i];
      end
    end
  end

  // Output register FSM
  out_state_t            state;
  out_state_t            state_nxt;
  logic [DATA_WIDTH-1:0] rdata_q;
  logic [DATA_WIDTH-1:0] rdata_nxt;
  logic [1:0]            rresp_q;
  logic [1:0]            rresp_nxt;
  logic                  can_load;

  // Loading while the master drains the held beat keeps one response per cycle.
  assign can_load = (state == OUT_EMPTY) || m_rready_i;

  always_comb begin
    state_nxt    = state;
    rdata_nxt    = rdata_q;
    rresp_nxt    = rresp_q;
    pop          = 1'b0;
    rgn_rready_o = '0;

    if ((state == OUT_HOLD) && m_rready_i) state_nxt = OUT_EMPTY;

    if (!trk_empty && can_load) begin
      if (head.illegal) begin
        pop       = 1'b1;
        rdata_nxt = '0;
        rresp_nxt = DECERR;
        state_nxt = OUT_HOLD;
      end else begin
        rgn_rready_o = head_dec;
        if (head_rvalid) begin
          pop       = 1'b1;
          rdata_nxt = head_rdata;
          rresp_nxt = head_rresp;
          state_nxt = OUT_HOLD;
        end
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state   <= OUT_EMPTY;
      rdata_q <= '0;
      rresp_q <= '0;
    end else begin
      state   <= state_nxt;
      rdata_q <= rdata_nxt;
      rresp_q <= rresp_nxt;
    end
  end

  assign m_rvalid_o = (state == OUT_HOLD);
  assign m_rdata_o  = rdata_q;
  assign m_rresp_o  = rresp_q;

`ifdef LITEIC_RESP_ERRCNT_EN
  // Counts error responses actually delivered to the master; sticks at all-ones.
  logic [15:0] err_cnt_q;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      err_cnt_q <= '0;
    end else if (m_rvalid_o && m_rready_i &&
                 ((m_rresp_o == SLVERR) || (m_rresp_o == DECERR)) &&
                 (err_cnt_q != 16'hFFFF)) begin
      err_cnt_q <= err_cnt_q + 16'd1;
    end
  end

  assign err_cnt_o = err_cnt_q;
`endif

endmodule
